uart_tx_engine: RTL and testbench

- Serial transmit stage that drains the UART TX FIFO. It pops one byte when the FIFO is non-empty and serialises it onto the tx line as an asynchronous frame: start bit, data bits LSB first, optional parity, stop bit(s).
- Sits directly downstream of the TX ring buffer. Drives the buffer's rd input and consumes its dout, empty and rst.
- Single clock domain.

---
 rtl/uart_tx_engine.sv | 141 ++++++++++++++
 tb/tb_uart_tx_engine.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// uart_tx_engine
//   Transmit stage that drains the TX FIFO. When enabled and the FIFO is
//   non-empty it pops one byte and sends it as an asynchronous frame:
//   start bit, DATA_BITS data bits LSB first, optional parity bit and
//   STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT clocks.
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   enable      permits starting a new frame (sampled only in IDLE)
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO read data, low DATA_BITS bits used
//   fifo_rd     one-cycle pop strobe, once per frame
//   tx          serial line, idles high
//   busy        high from the pop cycle through the last stop-bit cycle
//
// Handshake: the FIFO is popped with a single fifo_rd pulse in POP. The
// engine treats fifo_dout as valid from the following cycle and captures it
// at the end of LOAD; fifo_empty is only consulted in IDLE.
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic       ODD       = (PARITY_ODD != 0);
  localparam logic       PAR_ON    = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [BAUD_W-1:0]      baud_cnt;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shift;
  logic                   parity_acc;
  logic                   baud_tick;
  logic                   timed;

  assign baud_tick = (baud_cnt == BAUD_LAST);
  // Only the line-driving states run the baud counter.
  assign timed = (state == S_START) || (state == S_DATA) ||
                 (state == S_PARITY) || (state == S_STOP);

  always_comb begin
    state_next = state;
    tx         = 1'b1;
    busy       = 1'b1;
    fifo_rd    = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (enable && !fifo_empty) state_next = S_POP;
      end
      S_POP: begin
        fifo_rd    = 1'b1;
        state_next = S_LOAD;
      end
      S_LOAD: begin
        state_next = S_START;
      end
      S_START: begin
        tx = 1'b0;
        if (baud_tick) state_next = S_DATA;
      end
      S_DATA: begin
        tx = shift[0];
        if (baud_tick && (bit_cnt == DATA_LAST))
          state_next = PAR_ON ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        tx = parity_acc ^ ODD;
        if (baud_tick) state_next = S_STOP;
      end
      S_STOP: begin
        if (baud_tick && (bit_cnt == STOP_LAST)) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_acc <= 1'b0;
    end else begin
      state <= state_next;

      // Counters restart on every state entry; bit_cnt counts data bits in
      // DATA and stop bits in STOP.
      if (state_next != state) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (!timed) begin
        baud_cnt <= '0;
      end else if (baud_tick) begin
        baud_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end

      if (state == S_LOAD) begin
        shift      <= fifo_dout[DATA_BITS-1:0];
        parity_acc <= 1'b0;
      end else if ((state == S_DATA) && baud_tick) begin
        shift      <= shift >> 1;
        parity_acc <= parity_acc ^ shift[0];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine
//   Directed bench for uart_tx_engine at CLKS_PER_BIT=4. Four instances
//   cover 8N1, 8E1, 8O1 and 8N2; each has its own enable so only one is
//   active at a time while they share rst and the FIFO inputs.
module tb_uart_tx_engine;

  localparam int NCFG = 4;
  localparam int CAP  = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       en     [NCFG];
  logic       tx_o   [NCFG];
  logic       busy_o [NCFG];
  logic       rd_o   [NCFG];

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] fifo_q[$];
  logic       cap_tx   [CAP];
  logic       cap_busy [CAP];
  logic       cap_rd   [CAP];

  typedef struct {
    string      name;
    int         cfg;
    logic [7:0] data;
    logic [11:0] frame;   // bit k = k-th bit on the line
    int         nbits;
    int         busy_cycles;
  } vec_t;

  vec_t vecs[6];

  // ---------------- clock / DUTs ----------------
  always #5 clk = ~clk;

  uart_tx_engine #(.CLKS_PER_BIT(4)) dut_8n1 (
    .clk(clk), .rst(rst), .enable(en[0]), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd(rd_o[0]), .tx(tx_o[0]), .busy(busy_o[0]));

  uart_tx_engine #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_8e1 (
    .clk(clk), .rst(rst), .enable(en[1]), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd(rd_o[1]), .tx(tx_o[1]), .busy(busy_o[1]));

  uart_tx_engine #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut_8o1 (
    .clk(clk), .rst(rst), .enable(en[2]), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd(rd_o[2]), .tx(tx_o[2]), .busy(busy_o[2]));

  uart_tx_engine #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut_8n2 (
    .clk(clk), .rst(rst), .enable(en[3]), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd(rd_o[3]), .tx(tx_o[3]), .busy(busy_o[3]));

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Sample the current negedge as index 0, then n-1 further negedges.
  // Acts as the FIFO: on a pop the next byte is presented on fifo_dout.
  task automatic capture(input int cfg, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      cap_tx[i]   = tx_o[cfg];
      cap_busy[i] = busy_o[cfg];
      cap_rd[i]   = rd_o[cfg];
      if (cap_rd[i]) begin
        if (fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
      end
    end
  endtask

  task automatic check_frame(input string name, input int start,
                             input logic [11:0] frame, input int nbits);
    for (int k = 0; k < nbits; k++)
      check($sformatf("%s_bit%0d", name, k),
            32'(cap_tx[start + 4*k + 2]), 32'(frame[k]));
  endtask

  task automatic run_vector(input vec_t v);
    int nbusy;
    int nrd;
    fifo_q = {v.data};
    fifo_empty = 1'b0;
    en[v.cfg] = 1'b1;
    @(negedge clk);
    check({v.name, "_pop_latency"}, 32'(rd_o[v.cfg]), 32'd1);
    capture(v.cfg, v.busy_cycles + 6);
    en[v.cfg] = 1'b0;
    check({v.name, "_pre_start"}, 32'({cap_tx[0], cap_tx[1]}), 32'd3);
    check_frame(v.name, 2, v.frame, v.nbits);
    nbusy = 0;
    nrd = 0;
    for (int i = 0; i < v.busy_cycles + 6; i++) begin
      if (cap_busy[i]) nbusy++;
      if (cap_rd[i]) nrd++;
    end
    check({v.name, "_busy_cycles"}, 32'(nbusy), 32'(v.busy_cycles));
    check({v.name, "_rd_count"}, 32'(nrd), 32'd1);
  endtask

  task automatic back_to_back(input string name, input int cfg,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [11:0] f0, input logic [11:0] f1,
                              input int nbits, input int frame_cyc,
                              input int stop_cyc);
    int g;
    int nhigh;
    int nrd;
    fifo_q = {b0, b1};
    fifo_empty = 1'b0;
    en[cfg] = 1'b1;
    @(negedge clk);
    check({name, "_pop_latency"}, 32'(rd_o[cfg]), 32'd1);
    capture(cfg, 2 * (frame_cyc + 3) + 8);
    en[cfg] = 1'b0;
    check_frame({name, "_f0"}, 2, f0, nbits);
    g = 2 + frame_cyc;
    nhigh = 0;
    for (int i = g - stop_cyc; i < g; i++) if (cap_tx[i]) nhigh++;
    check({name, "_stop_high"}, 32'(nhigh), 32'(stop_cyc));
    nhigh = 0;
    for (int i = g; i < g + 3; i++) if (cap_tx[i]) nhigh++;
    check({name, "_gap_high"}, 32'(nhigh), 32'd3);
    check({name, "_second_start"}, 32'(cap_tx[g + 3]), 32'd0);
    check({name, "_second_pop"}, 32'(cap_rd[g + 1]), 32'd1);
    check_frame({name, "_f1"}, g + 3, f1, nbits);
    nrd = 0;
    for (int i = 0; i < 2 * (frame_cyc + 3) + 8; i++) if (cap_rd[i]) nrd++;
    check({name, "_rd_count"}, 32'(nrd), 32'd2);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int bad;

    vecs[0] = '{"a5_8n1",   0, 8'hA5, 12'({1'b1, 8'hA5, 1'b0}), 10, 42};
    vecs[1] = '{"00_8n1",   0, 8'h00, 12'({1'b1, 8'h00, 1'b0}), 10, 42};
    vecs[2] = '{"ff_8n1",   0, 8'hFF, 12'({1'b1, 8'hFF, 1'b0}), 10, 42};
    vecs[3] = '{"07_even",  1, 8'h07, 12'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 46};
    vecs[4] = '{"07_odd",   2, 8'h07, 12'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 46};
    vecs[5] = '{"55_8n2",   3, 8'h55, 12'({2'b11, 8'h55, 1'b0}), 11, 46};

    for (int c = 0; c < NCFG; c++) en[c] = 1'b0;

    // reset
    repeat (3) @(negedge clk);
    for (int c = 0; c < NCFG; c++)
      check($sformatf("reset_cfg%0d", c),
            32'({tx_o[c], busy_o[c], rd_o[c]}), 32'b100);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset_idle", 32'({tx_o[0], busy_o[0], rd_o[0]}), 32'b100);

    // single frames across configurations
    for (int i = 0; i < 6; i++) run_vector(vecs[i]);

    // back-to-back frames
    back_to_back("b2b_8n1", 0, 8'h00, 8'hFF,
                 12'({1'b1, 8'h00, 1'b0}), 12'({1'b1, 8'hFF, 1'b0}), 10, 40, 4);
    back_to_back("b2b_8n2", 3, 8'h55, 8'h55,
                 12'({2'b11, 8'h55, 1'b0}), 12'({2'b11, 8'h55, 1'b0}), 11, 44, 8);

    // enable low with data waiting
    fifo_q = {8'h3C};
    fifo_empty = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_o[0] !== 1'b1 || busy_o[0] !== 1'b0 || rd_o[0] !== 1'b0) bad++;
    end
    check("enable_low_hold", 32'(bad), 32'd0);
    en[0] = 1'b1;
    @(negedge clk);
    check("pop_after_enable", 32'(rd_o[0]), 32'd1);
    capture(0, 48);
    en[0] = 1'b0;
    check_frame("3c_8n1", 2, 12'({1'b1, 8'h3C, 1'b0}), 10);

    // reset during data bit 3 of 0xA5
    fifo_dout = 8'hA5;
    fifo_empty = 1'b0;
    en[0] = 1'b1;
    @(negedge clk);
    check("rst_test_pop", 32'(rd_o[0]), 32'd1);
    fifo_empty = 1'b1;
    repeat (19) @(negedge clk);
    check("before_rst_d3", 32'({tx_o[0], busy_o[0]}), 32'b01);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_frame", 32'({tx_o[0], busy_o[0], rd_o[0]}), 32'b100);
    rst = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_o[0] !== 1'b1 || busy_o[0] !== 1'b0 || rd_o[0] !== 1'b0) bad++;
    end
    check("no_resume_after_rst", 32'(bad), 32'd0);
    en[0] = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
